// File: rtl/game_flow_fsm_pkg.sv
// Shared pong match-flow types: state encoding, serve directions, winner codes.
// Latency: n/a (types, constants and a pure win-check function only).
// Backpressure: n/a.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    PAUSED    = 3'd3,
    POINT     = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;  // serve toward player 1
  localparam logic DIR_RIGHT = 1'b1;  // serve toward player 2

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  // A saturated counter always wins: once pinned at its maximum the lead can
  // no longer grow, so win-by-two would otherwise stall the match forever.
  function automatic logic has_won(input int unsigned mine,
                                   input int unsigned other,
                                   input int unsigned win_score,
                                   input logic        by_two,
                                   input int unsigned sat_val);
    if (mine == sat_val) return 1'b1;
    if (mine < win_score) return 1'b0;
    return !by_two || (mine >= other + 32'd2);
  endfunction

endpackage

// File: rtl/game_flow_fsm_if.sv
// Match-flow bus between game_flow_fsm, the ball controller and the renderers.
// Latency: n/a (signal bundle). Backpressure: none, all signals are levels or one-cycle pulses.
// Ports: inputs timing_tick/start/pause/goal_left/goal_right; outputs ball_run/ball_reset/
//        serve_dir/player1_score/player2_score/game_over/winner/state_o.
interface game_flow_fsm_if #(parameter int SCORE_W = 4);

  logic               timing_tick;
  logic               start;
  logic               pause;
  logic               goal_left;
  logic               goal_right;
  logic               ball_run;
  logic               ball_reset;
  logic               serve_dir;
  logic [SCORE_W-1:0] player1_score;
  logic [SCORE_W-1:0] player2_score;
  logic               game_over;
  logic [1:0]         winner;
  logic [2:0]         state_o;

  // master: the match-flow FSM itself
  modport master (
    input  timing_tick, start, pause, goal_left, goal_right,
    output ball_run, ball_reset, serve_dir, player1_score, player2_score,
           game_over, winner, state_o
  );

  // slave: the surrounding ball controller / renderers / stimulus
  modport slave (
    output timing_tick, start, pause, goal_left, goal_right,
    input  ball_run, ball_reset, serve_dir, player1_score, player2_score,
           game_over, winner, state_o
  );

endinterface

// File: rtl/game_flow_fsm_score_counter.sv
// Per-player saturating score counter with synchronous clear (clear beats increment).
// Latency: 1 cycle from i_inc/i_clr to o_score.
// Backpressure: none; increments at the maximum are dropped rather than wrapped.
// Ports: clk, rst_n, i_clr, i_inc in; o_score out (SCORE_W).
module score_counter #(
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [SCORE_W-1:0] o_score
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  logic [SCORE_W-1:0] r_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score <= '0;
    end else if (i_clr) begin
      r_score <= '0;
    end else if (i_inc && (r_score != SCORE_MAX)) begin
      r_score <= r_score + SCORE_ONE;
    end
  end

  assign o_score = r_score;

endmodule

// File: rtl/game_flow_fsm.sv
// Pong match flow: idle, timed serve, rally, pause, point scoring, win detection, rematch.
// Latency: start/pause edges act 2 cycles after the level rises; outputs follow state by 1 cycle.
// Backpressure: none; goal pulses outside PLAY and pause edges outside PLAY/PAUSED are dropped.
// Ports: clk, rst_n plain; bus (game_flow_fsm_if.master) carries the tick/button/goal inputs
//        and the ball control, score, winner and state outputs.
module game_flow_fsm
  import pong_pkg::*;
#(
  parameter int SCORE_W         = 4,
  parameter int WIN_SCORE       = 11,
  parameter bit WIN_BY_TWO      = 1'b0,
  parameter int SERVE_DELAY     = 60,
  parameter bit FIRST_SERVE_DIR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  game_flow_fsm_if.master  bus
);

  // A delay of 0 behaves like 1: the first tick in SERVE releases the ball.
  localparam int SERVE_LAST = (SERVE_DELAY <= 1) ? 0 : SERVE_DELAY - 1;
  localparam int CNT_W      = (SERVE_LAST < 2) ? 1 : $clog2(SERVE_LAST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_LAST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int unsigned SAT_VAL = (SCORE_W >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << SCORE_W) - 32'd1);

  state_t           r_state;
  logic [CNT_W-1:0] r_serve_cnt;
  logic             r_serve_dir;
  logic [1:0]       r_winner;
  logic             r_start_s, r_start_d;
  logic             r_pause_s, r_pause_d;
  logic             r_armed;
  logic             r_ball_run;
  logic             r_ball_reset;
  logic             r_game_over;
  state_t           r_state_o;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dir_nxt;
  logic [1:0]       w_winner_nxt;
  logic             w_p1_inc, w_p2_inc, w_clr;
  logic             w_start_rise, w_pause_rise;
  logic             w_p1_win, w_p2_win;

  // Edge detectors. During the first cycle after reset the delayed copy loads
  // straight from the pin, so a button already held at reset release reads as
  // "no edge" and a fresh press is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_s <= 1'b0;
      r_start_d <= 1'b0;
      r_pause_s <= 1'b0;
      r_pause_d <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_start_s <= bus.start;
      r_pause_s <= bus.pause;
      r_start_d <= r_armed ? r_start_s : bus.start;
      r_pause_d <= r_armed ? r_pause_s : bus.pause;
      r_armed   <= 1'b1;
    end
  end

  assign w_start_rise = r_start_s & ~r_start_d;
  assign w_pause_rise = r_pause_s & ~r_pause_d;

  // Scores seen in POINT already include the goal just taken.
  assign w_p1_win = has_won(32'(bus.player1_score), 32'(bus.player2_score),
                            32'(WIN_SCORE), WIN_BY_TWO, SAT_VAL);
  assign w_p2_win = has_won(32'(bus.player2_score), 32'(bus.player1_score),
                            32'(WIN_SCORE), WIN_BY_TWO, SAT_VAL);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_serve_cnt;
    w_dir_nxt    = r_serve_dir;
    w_winner_nxt = r_winner;
    w_p1_inc     = 1'b0;
    w_p2_inc     = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_rise) begin
          w_clr       = 1'b1;
          w_dir_nxt   = FIRST_SERVE_DIR;
          w_state_nxt = SERVE;
        end
      end
      SERVE: begin
        if (bus.timing_tick) begin
          if (r_serve_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = PLAY;
          end else begin
            w_cnt_nxt = r_serve_cnt + CNT_ONE;
          end
        end
      end
      PLAY: begin
        // Double goal is a glitch in the ball controller: replay the serve.
        if (bus.goal_left && bus.goal_right) begin
          w_state_nxt = SERVE;
        end else if (bus.goal_left) begin
          w_p2_inc    = 1'b1;
          w_dir_nxt   = DIR_LEFT;
          w_state_nxt = POINT;
        end else if (bus.goal_right) begin
          w_p1_inc    = 1'b1;
          w_dir_nxt   = DIR_RIGHT;
          w_state_nxt = POINT;
        end else if (w_pause_rise) begin
          w_state_nxt = PAUSED;
        end
      end
      PAUSED: begin
        if (w_pause_rise) w_state_nxt = PLAY;
      end
      POINT: begin
        // Only the scorer of the last point can have crossed the threshold.
        if (w_p1_win) begin
          w_winner_nxt = WIN_P1;
          w_state_nxt  = GAME_OVER;
        end else if (w_p2_win) begin
          w_winner_nxt = WIN_P2;
          w_state_nxt  = GAME_OVER;
        end else begin
          w_state_nxt = SERVE;
        end
      end
      GAME_OVER: begin
        if (w_start_rise) begin
          w_clr        = 1'b1;
          w_winner_nxt = WIN_NONE;
          w_dir_nxt    = FIRST_SERVE_DIR;
          w_state_nxt  = SERVE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_serve_cnt <= '0;
      r_serve_dir <= FIRST_SERVE_DIR;
      r_winner    <= WIN_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_serve_cnt <= w_cnt_nxt;
      r_serve_dir <= w_dir_nxt;
      r_winner    <= w_winner_nxt;
    end
  end

  // Ball and status outputs are decoded from the settled state one cycle
  // later. The ball is only left in place while rallying or frozen by pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ball_run   <= 1'b0;
      r_ball_reset <= 1'b1;
      r_game_over  <= 1'b0;
      r_state_o    <= IDLE;
    end else begin
      r_ball_run   <= (r_state == PLAY);
      r_ball_reset <= !((r_state == PLAY) || (r_state == PAUSED));
      r_game_over  <= (r_state == GAME_OVER);
      r_state_o    <= r_state;
    end
  end

  score_counter #(.SCORE_W(SCORE_W)) u_p1_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_inc   (w_p1_inc),
    .o_score (bus.player1_score)
  );

  score_counter #(.SCORE_W(SCORE_W)) u_p2_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_inc   (w_p2_inc),
    .o_score (bus.player2_score)
  );

  assign bus.ball_run   = r_ball_run;
  assign bus.ball_reset = r_ball_reset;
  assign bus.serve_dir  = r_serve_dir;
  assign bus.game_over  = r_game_over;
  assign bus.winner     = r_winner;
  assign bus.state_o    = r_state_o;

endmodule

// File: doc/game_flow_fsm.md
Name: game_flow_fsm

Overview:
Parametrised two-player successor to the current game-logic top level. It owns the full match flow for pong: idle, timed serve, rally, pause, point scoring, win detection and rematch. It sits between the ball controller (goal pulses in; run and reset controls out) and the score/overlay renderers (scores, winner and state out). It replaces the free-running score controller with a state-driven scorer that supports a configurable win score and a win-by-two rule.

Parameters:
SCORE_W, 4, width of each score counter
WIN_SCORE, 11, points needed to win; legal range 1..2^SCORE_W-1
WIN_BY_TWO, 0, 1 = winner must also lead by at least 2 points
SERVE_DELAY, 60, timing_tick count spent in SERVE before the ball is released
FIRST_SERVE_DIR, 0, serve direction for the first serve of a match (0 = toward player 1/left, 1 = toward player 2/right)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
timing_tick  in  1  one-cycle frame-rate tick
start  in  1  level from debouncer; acted on at its rising edge
pause  in  1  level from debouncer; acted on at its rising edge
goal_left  in  1  one-cycle pulse: ball left the field on the left (player 2 scores)
goal_right  in  1  one-cycle pulse: ball left the field on the right (player 1 scores)
ball_run  out  1  ball controller may advance the ball
ball_reset  out  1  ball controller holds the ball at centre
serve_dir  out  1  direction of the next or current serve
player1_score  out  SCORE_W  player 1 points
player2_score  out  SCORE_W  player 2 points
game_over  out  1  high while in GAME_OVER
winner  out  2  0 = none, 1 = player 1, 2 = player 2
state_o  out  3  current state encoding, for debug/overlay

Behaviour:
- Reset (asynchronous, while rst_n=0): state IDLE, both scores 0, ball_run 0, ball_reset 1, serve_dir FIRST_SERVE_DIR, game_over 0, winner 0, serve counter 0, edge-detect registers 0.
- All outputs are registered. Outputs are valid one cycle after a state change.
- start_rise and pause_rise are internal single-cycle edges of registered copies of start and pause.
- IDLE: ball_reset=1, ball_run=0. On start_rise: clear scores, serve_dir=FIRST_SERVE_DIR, go to SERVE.
- SERVE: ball_reset=1, ball_run=0. The counter increments on each timing_tick. When the counter reaches SERVE_DELAY-1 on a tick, clear the counter and go to PLAY. SERVE_DELAY=0 is treated as 1. pause_rise and goal pulses are ignored.
- PLAY: ball_reset=0, ball_run=1. Priority order:
  1. goal_left and goal_right together: no score change; go to SERVE with serve_dir unchanged.
  2. goal_left: player2_score+1; serve_dir=0 (serve toward the loser, player 1); go to POINT.
  3. goal_right: player1_score+1; serve_dir=1; go to POINT.
  4. pause_rise: go to PAUSED.
  A goal pulse wins over a pause_rise in the same cycle.
- PAUSED: ball_run=0, ball_reset=0 (ball frozen in place). Goal pulses are ignored. pause_rise returns to PLAY. start_rise is ignored.
- POINT: lasts exactly one cycle. A player wins when their score >= WIN_SCORE and either WIN_BY_TWO=0 or their score - opponent score >= 2.
  - Saturation override: if a score equals 2^SCORE_W-1, that player wins regardless of lead.
  - If a player wins: winner=1 or 2, go to GAME_OVER. Otherwise go to SERVE.
- Score increments saturate at 2^SCORE_W-1 and never wrap.
- GAME_OVER: game_over=1, ball_reset=1, ball_run=0. Scores and winner are held. start_rise clears scores and winner, sets serve_dir=FIRST_SERVE_DIR, and goes to SERVE.
- Reset asserted in any state, including mid-serve or paused, returns all state to the reset values immediately.
- A start level already held high at reset release does not trigger; a fresh rising edge is required.

Decomposition:
- Shared package pong_pkg holds:
  - state enum: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, POINT=4, GAME_OVER=5
  - DIR_LEFT/DIR_RIGHT constants
  - winner codes: WIN_NONE, WIN_P1, WIN_P2
- One natural sub-module, score_counter (parametrised by SCORE_W). It has saturating increment and synchronous clear, and is instantiated once per player. The FSM, serve timer and edge detectors stay in game_flow_fsm.

Test Plan:
- Reset, then start rise, then 60 ticks (defaults) -> SERVE lasts exactly 60 ticks; ball_run rises one cycle after the 60th tick; serve_dir=0.
- In PLAY, 11 goal_right pulses, each followed by a full serve -> player1_score=11, POINT then GAME_OVER, winner=1, game_over=1, ball_run=0.
- WIN_BY_TWO=1, scores driven to 10-10, then P1 to 11-10 -> no win; then 12-10 -> winner=1.
- SCORE_W=2, WIN_SCORE=3, WIN_BY_TWO=1, scores driven to 2-2, then P2 scores -> player2_score saturates at 3 and is never 0; winner=2 via the saturation override.
- PLAY, pause rise -> PAUSED with ball_run=0 and ball_reset=0; goal_left while paused -> scores unchanged; pause rise again -> PLAY.
- goal_left and goal_right in the same cycle -> scores unchanged, SERVE entered, serve_dir kept. rst_n pulsed low mid-SERVE -> all outputs at reset values within the reset assertion.
